branch_recovery_ctrl: RTL and testbench
=======================================

// Module: branch_recovery_ctrl
// PURPOSE
//  Tracks in-flight predicted branches (Bcond/Jcond) between fetch and EX resolution and sequences PC recovery.
//  Per prediction: stores the alternate (not-chosen) PC in an in-order queue. Pops the oldest entry on resolution.
//  On mispredict: drives mispredict/correct_pc to the PC block, clears wrong-path entries, holds a pipeline flush.
//  Also backpressures fetch via stall when the queue is full.
// PARAMETERS
//  ADDR_WIDTH    16  PC / address width
//  DEPTH         4   max outstanding unresolved branches (power of 2, >=2)
//  FLUSH_CYCLES  2   cycles o_flush stays high after a mispredict (>=1)
// PORTS
//  i_sys_clk        in   1                     clock, posedge
//  i_sys_rstn       in   1                     synchronous reset, active-low
//  i_br_valid       in   1                     fetch issued a predicted branch this cycle
//  i_br_pred_taken  in   1                     prediction for that branch
//  i_br_pc          in   ADDR_WIDTH            PC of the branch
//  i_br_target      in   ADDR_WIDTH            taken target of the branch
//  i_res_valid      in   1                     EX resolves the oldest outstanding branch
//  i_res_taken      in   1                     actual outcome
//  o_stall          out  1                     queue full; drives PC i_stall
//  o_mispredict     out  1                     1-cycle pulse; drives PC i_mispredict
//  o_correct_pc     out  ADDR_WIDTH            recovery PC, valid with o_mispredict
//  o_flush          out  1                     squash younger pipeline stages
//  o_outstanding    out  $clog2(DEPTH+1)       current queue occupancy
//  o_err            out  2                     sticky: [0] resolve on empty, [1] push on full
// BEHAVIOUR
//  - Reset (i_sys_rstn==0 at posedge): all outputs 0, queue empty, FSM=RUN. Applies mid-flush or with a full queue.
//  - Entry {pred_taken, alt_pc}:
//      alt_pc = pred_taken ? i_br_pc+1 : i_br_target
//      +1 is modulo 2^ADDR_WIDTH, so 0xFFFF wraps to 0x0000.
//  - FSM states RUN and FLUSH.
//  - RUN, push:
//      i_br_valid pushes an entry.
//      If full and no pop in the same cycle: push dropped, o_err[1] set.
//  - RUN, resolve:
//      i_res_valid pops the oldest entry.
//      If empty: ignored, o_err[0] set.
//      mismatch = i_res_taken != entry.pred_taken.
//  - Simultaneous push+pop with no mismatch: both occur, occupancy unchanged. This is legal at full.
//  - On mismatch:
//      o_mispredict=1 and o_correct_pc=alt_pc, both registered: valid the cycle after i_res_valid, high exactly 1 cycle.
//      Queue cleared on the same edge. Any same-cycle push is discarded (wrong path).
//      FSM -> FLUSH with counter = FLUSH_CYCLES.
//  - FLUSH:
//      o_flush=1 from the cycle o_mispredict rises, for exactly FLUSH_CYCLES cycles.
//      i_br_valid and i_res_valid ignored; no error bits set.
//      Counter reaches 0 -> RUN.
//  - o_stall = (occupancy==DEPTH), registered-state-derived. No combinational path from inputs.
//  - o_correct_pc holds its last value when o_mispredict=0.
//  - o_err bits are sticky until reset.
// STRUCTURE
//  - Package pc_ctrl_pkg:
//      typedef enum logic {RUN, FLUSH} rec_state_e
//      typedef struct packed {logic pred_taken; logic [ADDR_WIDTH-1:0] alt_pc;} br_entry_t
//      localparam defaults ADDR_WIDTH=16, DEPTH=4
//  - Sub-module br_fifo: circular buffer of br_entry_t with wr_en, rd_en, sync clear, count, full/empty.
//  - Top: FSM, flush counter, alt_pc compute, mismatch compare, output registers, error flags.
// TESTING
//  1. Reset: hold i_sys_rstn low 30 cycles with random inputs -> all outputs 0, o_outstanding=0.
//  2. Correct taken: push pc=20, tgt=36, pred=1; then resolve taken -> occupancy 1->0, no o_mispredict/o_flush.
//  3. Taken mispredict: push pc=36, tgt=52, pred=1, plus 2 more pushes; resolve not-taken ->
//     next cycle o_mispredict=1, o_correct_pc=37; o_flush high 2 cycles; o_outstanding=0; pushes during flush dropped.
//  4. Not-taken mispredict: push pc=38, tgt=50, pred=0; resolve taken -> o_correct_pc=50 one cycle later, o_flush 2 cycles.
//  5. Full: 4 pushes -> o_stall=1.
//     Push+correct pop at full -> occupancy stays 4.
//     Lone 5th push -> dropped, o_err=2'b10.
//  6. Edges:
//     Resolve on empty -> o_err[0]=1, no mispredict.
//     pc=0xFFFF pred=1, resolve not-taken -> o_correct_pc=0x0000.
//     Reset asserted mid-flush -> o_flush=0 and FSM=RUN next cycle.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_ctrl_pkg
//  Description : Shared types and default sizes for branch recovery control.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_ctrl_pkg;

    localparam int C_ADDR_WIDTH   = 16;
    localparam int C_DEPTH        = 4;
    localparam int C_FLUSH_CYCLES = 2;

    // Recovery sequencer states
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rec_state_e;

    // One in-flight branch: its prediction and the PC not chosen by fetch
    typedef struct packed {
        logic                    pred_taken;
        logic [C_ADDR_WIDTH-1:0] alt_pc;
    } br_entry_t;

endpackage : pc_ctrl_pkg
`default_nettype wire

// File: rtl/br_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : br_fifo
//  Description : In-order circular buffer of branch entries with sync clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module br_fifo
    import pc_ctrl_pkg::*;
#(
    parameter int WIDTH = $bits(br_entry_t),
    parameter int DEPTH = C_DEPTH
) (
    input  logic                       i_sys_clk,
    input  logic                       i_sys_rstn,
    input  logic                       i_clear,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    // A write at full is only accepted when a read frees a slot the same cycle
    assign w_do_rd   = i_rd_en && !o_empty;
    assign w_do_wr   = i_wr_en && (!o_full || w_do_rd);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    // Pointer and occupancy tracking; clear discards everything in flight
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rstn || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_wr) - CNT_W'(w_do_rd);
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge i_sys_clk) begin
        if (w_do_wr && !i_clear) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule : br_fifo
`default_nettype wire

// File: rtl/branch_recovery_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_recovery_ctrl
//  Description : Tracks predicted branches until EX resolution and sequences
//                PC recovery (mispredict pulse, correct PC, pipeline flush).
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_recovery_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = C_ADDR_WIDTH,
    parameter int DEPTH        = C_DEPTH,
    parameter int FLUSH_CYCLES = C_FLUSH_CYCLES
) (
    input  logic                       i_sys_clk,
    input  logic                       i_sys_rstn,
    input  logic                       i_br_valid,
    input  logic                       i_br_pred_taken,
    input  logic [ADDR_WIDTH-1:0]      i_br_pc,
    input  logic [ADDR_WIDTH-1:0]      i_br_target,
    input  logic                       i_res_valid,
    input  logic                       i_res_taken,
    output logic                       o_stall,
    output logic                       o_mispredict,
    output logic [ADDR_WIDTH-1:0]      o_correct_pc,
    output logic                       o_flush,
    output logic [$clog2(DEPTH+1)-1:0] o_outstanding,
    output logic [1:0]                 o_err
);

    localparam int ENTRY_W = ADDR_WIDTH + 1;
    localparam int FCNT_W  = $clog2(FLUSH_CYCLES + 1);

    rec_state_e                r_state;
    logic [FCNT_W-1:0]         r_flush_cnt;
    logic                      r_mispredict;
    logic [ADDR_WIDTH-1:0]     r_correct_pc;
    logic                      r_flush;
    logic [1:0]                r_err;

    logic                      w_run;
    logic [ADDR_WIDTH-1:0]     w_alt_pc;
    logic [ENTRY_W-1:0]        w_wr_data;
    logic [ENTRY_W-1:0]        w_head;
    logic                      w_head_pred;
    logic [ADDR_WIDTH-1:0]     w_head_alt;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_pop;
    logic                      w_mismatch;
    logic                      w_push;

    // Entry layout matches br_entry_t: {pred_taken, alt_pc}
    assign w_run       = (r_state == RUN);
    assign w_alt_pc    = i_br_pred_taken ? (i_br_pc + ADDR_WIDTH'(1)) : i_br_target;
    assign w_wr_data   = {i_br_pred_taken, w_alt_pc};
    assign w_head_pred = w_head[ADDR_WIDTH];
    assign w_head_alt  = w_head[ADDR_WIDTH-1:0];

    // Pop only real entries; a mispredict squashes any same-cycle (wrong-path) push
    assign w_pop      = w_run && i_res_valid && !w_empty;
    assign w_mismatch = w_pop && (i_res_taken != w_head_pred);
    assign w_push     = w_run && i_br_valid && !w_mismatch && (!w_full || w_pop);

    br_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_sys_clk  (i_sys_clk),
        .i_sys_rstn (i_sys_rstn),
        .i_clear    (w_mismatch),
        .i_wr_en    (w_push),
        .i_wr_data  (w_wr_data),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_head),
        .o_count    (o_outstanding),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Recovery FSM with registered mispredict, correct PC, flush and error outputs
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rstn) begin
            r_state      <= RUN;
            r_flush_cnt  <= '0;
            r_mispredict <= 1'b0;
            r_correct_pc <= '0;
            r_flush      <= 1'b0;
            r_err        <= 2'b00;
        end else begin
            r_mispredict <= 1'b0;
            case (r_state)
                RUN: begin
                    if (i_res_valid && w_empty) r_err[0] <= 1'b1;
                    if (i_br_valid && w_full && !w_pop) r_err[1] <= 1'b1;
                    if (w_mismatch) begin
                        r_mispredict <= 1'b1;
                        r_correct_pc <= w_head_alt;
                        r_flush      <= 1'b1;
                        r_flush_cnt  <= FCNT_W'(FLUSH_CYCLES);
                        r_state      <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Flush was raised on the mispredict edge, so it drops after FLUSH_CYCLES cycles
                    if (r_flush_cnt <= FCNT_W'(1)) begin
                        r_flush_cnt <= '0;
                        r_flush     <= 1'b0;
                        r_state     <= RUN;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - FCNT_W'(1);
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign o_stall      = w_full;
    assign o_mispredict = r_mispredict;
    assign o_correct_pc = r_correct_pc;
    assign o_flush      = r_flush;
    assign o_err        = r_err;

endmodule : branch_recovery_ctrl
`default_nettype wire

// File: tb/tb_branch_recovery_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_recovery_ctrl
//  Description : Directed scoreboard bench for branch_recovery_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_recovery_ctrl;

    logic        clk;
    logic        i_sys_rstn;
    logic        i_br_valid;
    logic        i_br_pred_taken;
    logic [15:0] i_br_pc;
    logic [15:0] i_br_target;
    logic        i_res_valid;
    logic        i_res_taken;
    logic        o_stall;
    logic        o_mispredict;
    logic [15:0] o_correct_pc;
    logic        o_flush;
    logic [2:0]  o_outstanding;
    logic [1:0]  o_err;

    int          n_vec;
    int          n_bad;
    logic [15:0] sb_q[$];

    branch_recovery_ctrl #(
        .ADDR_WIDTH   (16),
        .DEPTH        (4),
        .FLUSH_CYCLES (2)
    ) dut (
        .i_sys_clk       (clk),
        .i_sys_rstn      (i_sys_rstn),
        .i_br_valid      (i_br_valid),
        .i_br_pred_taken (i_br_pred_taken),
        .i_br_pc         (i_br_pc),
        .i_br_target     (i_br_target),
        .i_res_valid     (i_res_valid),
        .i_res_taken     (i_res_taken),
        .o_stall         (o_stall),
        .o_mispredict    (o_mispredict),
        .o_correct_pc    (o_correct_pc),
        .o_flush         (o_flush),
        .o_outstanding   (o_outstanding),
        .o_err           (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every mispredict pulse must match the oldest expected recovery PC
    always @(negedge clk) begin
        if (o_mispredict) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_mispredict: got pc=%h, none expected", o_correct_pc);
            end else begin
                logic [15:0] exp_pc;
                exp_pc = sb_q.pop_front();
                if (o_correct_pc !== exp_pc) begin
                    n_bad++;
                    $display("FAIL correct_pc: got %h, expected %h", o_correct_pc, exp_pc);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then return just after the capturing edge
    task automatic step(input logic bv, input logic bp, input logic [15:0] pc,
                        input logic [15:0] tgt, input logic rv, input logic rt);
        i_br_valid      = bv;
        i_br_pred_taken = bp;
        i_br_pc         = pc;
        i_br_target     = tgt;
        i_res_valid     = rv;
        i_res_taken     = rt;
        @(posedge clk);
        #1;
        i_br_valid  = 1'b0;
        i_res_valid = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        i_sys_rstn = 1'b0;
        i_br_valid = 1'b0; i_br_pred_taken = 1'b0; i_br_pc = '0; i_br_target = '0;
        i_res_valid = 1'b0; i_res_taken = 1'b0;
        @(posedge clk); #1;

        // 1. Reset held with random inputs
        for (int i = 0; i < 30; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("rst_outstanding", int'(o_outstanding), 0);
        chk("rst_flags", int'({o_stall, o_mispredict, o_flush, o_err}), 0);
        chk("rst_correct_pc", int'(o_correct_pc), 0);
        i_sys_rstn = 1'b1;

        // 2. Correctly predicted taken branch
        step(1, 1, 16'd20, 16'd36, 0, 0);
        chk("t2_occ_push", int'(o_outstanding), 1);
        step(0, 0, 0, 0, 1, 1);
        chk("t2_occ_pop", int'(o_outstanding), 0);
        chk("t2_no_recover", int'({o_mispredict, o_flush}), 0);

        // 3. Taken mispredict with younger entries and a wrong-path push
        step(1, 1, 16'd36, 16'd52, 0, 0);
        step(1, 0, 16'd40, 16'd60, 0, 0);
        step(1, 1, 16'd41, 16'd70, 0, 0);
        chk("t3_occ3", int'(o_outstanding), 3);
        sb_q.push_back(16'd37);
        step(1, 1, 16'd50, 16'd90, 1, 0);
        chk("t3_mispredict", int'(o_mispredict), 1);
        chk("t3_flush_c1", int'(o_flush), 1);
        chk("t3_occ_cleared", int'(o_outstanding), 0);
        step(1, 1, 16'd60, 16'd80, 1, 1);
        chk("t3_flush_c2", int'({o_mispredict, o_flush}), 1);
        chk("t3_occ_flush_drop", int'(o_outstanding), 0);
        step(1, 1, 16'd61, 16'd81, 0, 0);
        chk("t3_flush_end", int'(o_flush), 0);
        chk("t3_occ_flush_drop2", int'(o_outstanding), 0);
        chk("t3_pc_hold", int'(o_correct_pc), 37);
        chk("t3_no_err", int'(o_err), 0);

        // 4. Not-taken mispredict
        step(1, 0, 16'd38, 16'd50, 0, 0);
        sb_q.push_back(16'd50);
        step(0, 0, 0, 0, 1, 1);
        chk("t4_flush_c1", int'(o_flush), 1);
        step(0, 0, 0, 0, 0, 0);
        chk("t4_flush_c2", int'(o_flush), 1);
        step(0, 0, 0, 0, 0, 0);
        chk("t4_flush_end", int'(o_flush), 0);

        // 5. Full queue behaviour
        for (int i = 0; i < 4; i++) step(1, 1, 16'(100 + i), 16'd200, 0, 0);
        chk("t5_stall", int'(o_stall), 1);
        chk("t5_occ_full", int'(o_outstanding), 4);
        step(1, 1, 16'd104, 16'd200, 1, 1);
        chk("t5_occ_pushpop", int'(o_outstanding), 4);
        chk("t5_err_none", int'(o_err), 0);
        step(1, 1, 16'd105, 16'd200, 0, 0);
        chk("t5_occ_drop", int'(o_outstanding), 4);
        chk("t5_err_full", int'(o_err), 2);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 1);
        chk("t5_drained", int'({o_stall, o_outstanding}), 0);

        // 6. Edge cases
        step(0, 0, 0, 0, 1, 0);
        chk("t6_err_empty", int'(o_err), 3);
        chk("t6_no_mispredict", int'(o_mispredict), 0);
        step(1, 1, 16'hFFFF, 16'd5, 0, 0);
        sb_q.push_back(16'h0000);
        step(0, 0, 0, 0, 1, 0);
        chk("t6_wrap_flush", int'(o_flush), 1);
        i_sys_rstn = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        chk("t6_rst_flush", int'(o_flush), 0);
        chk("t6_rst_err", int'(o_err), 0);
        i_sys_rstn = 1'b1;
        step(1, 1, 16'd7, 16'd9, 0, 0);
        chk("t6_run_after_rst", int'(o_outstanding), 1);

        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_branch_recovery_ctrl
`default_nettype wire
